// File: rtl/multiply.sv
// -----------------------------------------------------------------------------
// multiply
//   Unsigned radix-2 shift-add sequential multiplier. It adds one partial
//   product per clock, so a WIDTH x WIDTH multiply takes exactly WIDTH cycles
//   from the accepting start edge to the done pulse, whatever the operands.
//   The result is the full 2*WIDTH-bit product and is never truncated.
//
// Ports
//   clk    in   1        rising-edge clock
//   rst_n  in   1        asynchronous active-low reset
//   start  in   1        sample a/b and begin; honoured only while idle
//   a      in   WIDTH    multiplicand, unsigned
//   b      in   WIDTH    multiplier, unsigned
//   busy   out  1        high while a multiplication is in progress
//   done   out  1        one-cycle pulse: c has just been updated
//   c      out  2*WIDTH  last completed product; held until the next one
// -----------------------------------------------------------------------------
module multiply #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   c
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [2*WIDTH-1:0]    mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]      mplier_q, mplier_d; // multiplier, shifted right each step
  logic [2*WIDTH-1:0]    acc_q, acc_d;
  logic [2*WIDTH-1:0]    c_q, c_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;

  logic                  last_step;
  logic [2*WIDTH-1:0]    acc_sum;

  // The step that consumes the final multiplier bit also publishes the result,
  // so completion lands exactly WIDTH edges after the accepting edge.
  assign last_step = (cnt_q == CW'(WIDTH - 1));
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = BUSY;
      BUSY:    if (last_step) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath next-values
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_step) begin
          c_d    = acc_sum;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == BUSY);
    done = done_q;
    c    = c_q;
  end

endmodule

// File: tb/tb_multiply.sv
module tb_multiply;

  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy;
  logic             done;
  logic [PW-1:0]    c;

  int errors = 0;
  int checks = 0;
  logic [PW-1:0] exp_q[$];

  always #5 clk = ~clk;

  multiply #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  // Drives a one-cycle start pulse from a negedge, records the expected
  // product, then scrambles the operand inputs. Returns at the next negedge.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [PW-1:0] xe, ye;
    xe = {{WIDTH{1'b0}}, x};
    ye = {{WIDTH{1'b0}}, y};
    a = x; b = y; start = 1'b1;
    exp_q.push_back(xe * ye);
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
  endtask

  // Waits (bounded) for done; reports negedges waited and whether c stayed
  // constant until done appeared.
  task automatic wait_done(output int lat, output bit stable);
    logic [PW-1:0] cprev;
    cprev  = c;
    stable = 1'b1;
    lat    = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (c !== cprev) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (c !== '0) begin errors++; $display("FAIL reset_c: got %h want 0", c); end
    start = 1'b1; a = 8'd9; b = 8'd9;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || c !== '0) begin
      errors++; $display("FAIL reset_hold: busy=%b c=%h want 0/0", busy, c);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_products();
    logic [WIDTH-1:0] xs[8] = '{8'd3, 8'd10, 8'd255, 8'd255, 8'd0, 8'd1, 8'd128, 8'd77};
    logic [WIDTH-1:0] ys[8] = '{8'd5, 8'd2, 8'd2, 8'd255, 8'd200, 8'd1, 8'd128, 8'd0};
    int lat; bit stable; logic [PW-1:0] e;
    for (int i = 0; i < 8; i++) begin
      issue(xs[i], ys[i]);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prod_busy[%0d]: got %b want 1", i, busy); end
      wait_done(lat, stable);
      checks++; if (lat != WIDTH) begin errors++; $display("FAIL prod_latency[%0d]: got %0d want %0d", i, lat, WIDTH); end
      checks++; if (!stable) begin errors++; $display("FAIL prod_c_stable[%0d]: c moved while busy", i); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prod_busy_end[%0d]: got %b want 0", i, busy); end
      e = exp_q.size() ? exp_q.pop_front() : 'x;
      checks++; if (c !== e) begin errors++; $display("FAIL prod_c[%0d] %0d*%0d: got %h want %h", i, xs[i], ys[i], c, e); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || c !== e) begin
        errors++; $display("FAIL prod_pulse[%0d]: done=%b c=%h want 0/%h", i, done, c, e);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat; bit stable; int extra; logic [PW-1:0] e;
    issue(8'd3, 8'd5);
    repeat (2) @(negedge clk);
    a = 8'd7; b = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, stable);
    checks++; if (lat + 3 != WIDTH) begin errors++; $display("FAIL ign_latency: got %0d want %0d", lat + 3, WIDTH); end
    e = exp_q.size() ? exp_q.pop_front() : 'x;
    checks++; if (c !== e) begin errors++; $display("FAIL ign_c: got %h want %h", c, e); end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ign_extra_op: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_async_reset();
    int lat; bit stable; int seen; logic [PW-1:0] e;
    issue(8'd255, 8'd255);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || c !== '0) begin
      errors++; $display("FAIL areset_now: busy=%b done=%b c=%h want 0/0/0", busy, done, c);
    end
    exp_q.delete();
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || c !== '0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL areset_quiet: got %0d bad cycles want 0", seen); end
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd10, 8'd2);
    wait_done(lat, stable);
    checks++; if (lat != WIDTH) begin errors++; $display("FAIL areset_latency: got %0d want %0d", lat, WIDTH); end
    e = exp_q.size() ? exp_q.pop_front() : 'x;
    checks++; if (c !== e) begin errors++; $display("FAIL areset_c: got %h want %h", c, e); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] xs[4] = '{8'd12, 8'd200, 8'd255, 8'd6};
    logic [WIDTH-1:0] ys[4] = '{8'd11, 8'd3, 8'd254, 8'd0};
    int lat; bit stable; logic [PW-1:0] e;
    start = 1'b1; a = xs[0]; b = ys[0];
    exp_q.push_back({{WIDTH{1'b0}}, xs[0]} * {{WIDTH{1'b0}}, ys[0]});
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wait_done(lat, stable);
      // Done-to-done spacing is this wait plus the one idle accept cycle.
      checks++; if (lat != WIDTH) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, WIDTH); end
      e = exp_q.size() ? exp_q.pop_front() : 'x;
      checks++; if (c !== e) begin errors++; $display("FAIL b2b_c[%0d]: got %h want %h", i, c, e); end
      if (i < 3) begin
        a = xs[i+1]; b = ys[i+1];
        exp_q.push_back({{WIDTH{1'b0}}, xs[i+1]} * {{WIDTH{1'b0}}, ys[i+1]});
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL b2b_restart[%0d]: done=%b busy=%b want 0/1", i, done, busy);
        end
      end else begin
        start = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
          errors++; $display("FAIL b2b_end: done=%b busy=%b want 0/0", done, busy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
